uart_cmd_wrapper: RTL and testbench
===================================

Name: uart_cmd_wrapper

Overview:
Receive-side counterpart of the remote command link. It sits on the robot/target side of the serial line. It assembles two consecutive UART bytes (high byte first, then low byte) into one 16-bit command and presents it with a ready flag to the command processor. It also transmits a one-byte response (ack/status) back over TX. An inter-byte timeout resynchronises framing if a low byte never arrives.

Parameters:
TIMEOUT_CYC, 1_000_000, clocks allowed between high-byte receipt and low-byte receipt before the frame is discarded; must exceed one full UART byte time.
TO_W, $clog2(TIMEOUT_CYC), width of the timeout counter (derived, not overridden).

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
RX  input  1  serial line in (idle high)
TX  output  1  serial line out (idle high)
clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy
cmd_rdy  output  1  a complete 16-bit command is valid on cmd
cmd  output  16  last complete command, {high_byte, low_byte}
send_resp  input  1  one-cycle pulse: transmit resp
resp  input  8  response byte, sampled on the send_resp cycle
resp_sent  output  1  response transmission complete
frame_err  output  1  one-cycle pulse: partial frame discarded by timeout

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - cmd_rdy = 0, resp_sent = 0, frame_err = 0.
  - cmd = 16'h0000, timer = 0, tx_busy = 0.
  - TX idles high.
  - Reset mid-frame discards any stored high byte.
- Internal UART instance (existing codebase UART, fixed baud): rx_rdy, rx_data, clr_rx_rdy, trmt, tx_data, tx_done.
- State machine, two states:
  - IDLE, waiting for the high byte. When rx_rdy is seen:
    - latch rx_data into high_byte;
    - pulse clr_rx_rdy;
    - clear cmd_rdy;
    - zero timer;
    - go to LOW_WAIT.
  - LOW_WAIT, waiting for the low byte.
    - If rx_rdy is seen:
      - pulse clr_rx_rdy;
      - register cmd <= {high_byte, rx_data};
      - set cmd_rdy;
      - go to IDLE.
      - cmd_rdy and the new cmd are visible 1 clk after the cycle rx_rdy is seen.
    - Else timer increments each clk. At timer == TIMEOUT_CYC-1:
      - frame_err is high for exactly 1 clk;
      - go to IDLE;
      - high_byte is discarded;
      - cmd and cmd_rdy are unchanged.
    - rx_rdy on the same cycle as the timeout terminal count: the byte wins and the frame completes; no frame_err.
- cmd register: updates only on frame completion; holds across clr_cmd_rdy, timeouts and new high bytes.
- cmd_rdy (set/reset flop):
  - set on frame completion;
  - cleared by clr_cmd_rdy or by receipt of a new high byte;
  - set has priority over clr_cmd_rdy on the same cycle.
- Response path:
  - send_resp with tx_busy = 0:
    - trmt = 1 the same cycle, tx_data = resp;
    - tx_busy <= 1;
    - resp_sent <= 0.
  - tx_done:
    - tx_busy <= 0;
    - resp_sent <= 1 (sticky until the next accepted send_resp).
  - send_resp while tx_busy = 1 is ignored: no trmt, resp_sent unaffected.
  - Response path is independent of receive state; full duplex.
- No overflow buffering: the command consumer must clear cmd_rdy before the next frame completes. Otherwise cmd is overwritten and cmd_rdy stays 1.

Decomposition:
- Shared package cmd_link_pkg:
  - state typedef enum {IDLE, LOW_WAIT};
  - localparam CMD_W = 16;
  - localparam DEFAULT_TIMEOUT_CYC.
- Sub-module: the existing UART (transceiver) instantiated as-is.
- Framing FSM, timer and response control stay in this module.

Test Plan:
- Bench UART sends 0xA5 then 0x3C back-to-back -> 1 clk after low-byte rx_rdy: cmd = 16'hA53C, cmd_rdy = 1; frame_err never pulses.
- After the previous scenario, pulse clr_cmd_rdy -> cmd_rdy = 0 next clk; cmd stays 16'hA53C. Then send 0x11 -> cmd_rdy stays 0 and cmd is still A53C until 0x22 completes; then cmd = 16'h1122.
- TIMEOUT_CYC = 60000 (sim), send 0x12 then silence -> frame_err high exactly 1 clk at 60000 clks after high-byte rx_rdy. Then send 0x56, 0x78 -> cmd = 16'h5678 (not 16'h1256).
- Assert clr_cmd_rdy on the exact completion cycle of frame 0xBE, 0xEF -> cmd_rdy = 1, cmd = 16'hBEEF.
- send_resp with resp = 8'hA5 -> bench decodes 0xA5 on TX; resp_sent = 0 until tx_done, then 1. A second send_resp mid-transmission -> no extra TX frame.
- Pull rst_n low after high byte 0x9C -> all outputs 0, cmd = 0. After release, send 0xCA, 0xFE -> cmd = 16'hCAFE.

Source files
------------

// File: rtl/cmd_link_pkg.sv
// Shared types and constants for the serial command link (receive side).
package cmd_link_pkg;

  // Command framing states.
  typedef enum logic {
    IDLE     = 1'b0,
    LOW_WAIT = 1'b1
  } state_e;

  // Receiver bit-level states inside the transceiver.
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam int CMD_W               = 16;
  localparam int DEFAULT_TIMEOUT_CYC = 1_000_000;

  // 7.3728 MHz system clock / 115200 baud.
  localparam int BAUD_CYC = 64;
  localparam int BAUD_W   = $clog2(BAUD_CYC);

endpackage

// File: rtl/uart_cmd_wrapper_uart.sv
// Fixed-baud 8N1 UART transceiver. rx_rdy holds until cleared or a new
// start bit arrives; tx_done is a one-cycle pulse after the stop bit.
module uart_cmd_wrapper_uart
  import cmd_link_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       tx_o,
  input  logic       clr_rx_rdy_i,
  output logic       rx_rdy_o,
  output logic [7:0] rx_data_o,
  input  logic       trmt_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_done_o
);

  localparam logic [BAUD_W-1:0] FULL_BIT = BAUD_W'(BAUD_CYC - 1);
  localparam logic [BAUD_W-1:0] HALF_BIT = BAUD_W'(BAUD_CYC / 2 - 1);

  logic              rx_meta_q, rx_sync_q;
  rx_state_e         rx_st_q, rx_st_d;
  logic [BAUD_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rx_rdy_q, rx_rdy_d;
  logic              rx_tc;

  logic              tx_busy_q, tx_busy_d;
  logic [9:0]        tx_shift_q, tx_shift_d;
  logic [BAUD_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]        tx_bit_q, tx_bit_d;
  logic              tx_done_q, tx_done_d;
  logic              tx_tc;

  assign rx_tc = (rx_cnt_q == '0);
  assign tx_tc = (tx_cnt_q == '0);

  // Two-flop synchroniser on the asynchronous serial input; idles high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receiver: find start edge, sample every bit at its centre, LSB first.
  always_comb begin
    rx_st_d    = rx_st_q;
    rx_cnt_d   = rx_tc ? rx_cnt_q : rx_cnt_q - 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_rdy_d   = rx_rdy_q & ~clr_rx_rdy_i;
    case (rx_st_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_st_d  = RX_START;
          rx_cnt_d = HALF_BIT;
          rx_rdy_d = 1'b0;
        end
      end
      RX_START: begin
        if (rx_tc) begin
          if (rx_sync_q) begin
            rx_st_d = RX_IDLE;  // glitch, not a real start bit
          end else begin
            rx_st_d  = RX_DATA;
            rx_cnt_d = FULL_BIT;
            rx_bit_d = 3'd0;
          end
        end
      end
      RX_DATA: begin
        if (rx_tc) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_cnt_d   = FULL_BIT;
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_tc) begin
          rx_st_d   = RX_IDLE;
          rx_data_d = rx_shift_q;
          rx_rdy_d  = 1'b1;
        end
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  // Receiver state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_st_q    <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_rdy_q   <= 1'b0;
    end else begin
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_rdy_q   <= rx_rdy_d;
    end
  end

  // Transmitter: shift out {stop, data, start}, one bit per baud period.
  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_tc ? tx_cnt_q : tx_cnt_q - 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_done_d  = 1'b0;
    if (!tx_busy_q) begin
      if (trmt_i) begin
        tx_busy_d  = 1'b1;
        tx_shift_d = {1'b1, tx_data_i, 1'b0};
        tx_cnt_d   = FULL_BIT;
        tx_bit_d   = 4'd0;
      end
    end else if (tx_tc) begin
      if (tx_bit_q == 4'd9) begin
        tx_busy_d = 1'b0;
        tx_done_d = 1'b1;
      end else begin
        tx_shift_d = {1'b1, tx_shift_q[9:1]};
        tx_cnt_d   = FULL_BIT;
        tx_bit_d   = tx_bit_q + 4'd1;
      end
    end
  end

  // Transmitter state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_busy_q  <= 1'b0;
      tx_shift_q <= '1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_busy_q  <= tx_busy_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign tx_o      = tx_busy_q ? tx_shift_q[0] : 1'b1;
  assign rx_rdy_o  = rx_rdy_q;
  assign rx_data_o = rx_data_q;
  assign tx_done_o = tx_done_q;

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Receive-side command link: pairs two UART bytes (high then low) into a
// 16-bit command with a ready flag, and sends one-byte responses back.
//
//   state    | meaning
//   ---------+----------------------------------------------------
//   IDLE     | waiting for the high byte of a command
//   LOW_WAIT | high byte held, waiting for low byte; timer running
module uart_cmd_wrapper
  import cmd_link_pkg::*;
#(
  parameter  int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
  localparam int TO_W        = $clog2(TIMEOUT_CYC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RX,
  output logic             TX,
  input  logic             clr_cmd_rdy,
  output logic             cmd_rdy,
  output logic [CMD_W-1:0] cmd,
  input  logic             send_resp,
  input  logic [7:0]       resp,
  output logic             resp_sent,
  output logic             frame_err
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic             rx_rdy;
  logic [7:0]       rx_data;
  logic             clr_rx_rdy;
  logic             trmt;
  logic [7:0]       tx_data;
  logic             tx_done;

  state_e           state_q, state_d;
  logic [7:0]       high_byte_q, high_byte_d;
  logic [TO_W-1:0]  timer_q, timer_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             cmd_rdy_q, cmd_rdy_d;
  logic             tx_busy_q, tx_busy_d;
  logic             resp_sent_q, resp_sent_d;
  logic             to_tc;

  uart_cmd_wrapper_uart u_uart (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rx_i         (RX),
    .tx_o         (TX),
    .clr_rx_rdy_i (clr_rx_rdy),
    .rx_rdy_o     (rx_rdy),
    .rx_data_o    (rx_data),
    .trmt_i       (trmt),
    .tx_data_i    (tx_data),
    .tx_done_o    (tx_done)
  );

  assign to_tc = (timer_q == TO_LAST);

  // Framing state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next framing state; an arriving byte beats the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (rx_rdy)          state_d = LOW_WAIT;
      LOW_WAIT: if (rx_rdy || to_tc) state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // Framing outputs and datapath next values.
  always_comb begin
    clr_rx_rdy  = rx_rdy;
    frame_err   = 1'b0;
    high_byte_d = high_byte_q;
    timer_d     = timer_q;
    cmd_d       = cmd_q;
    // set on completion below overrides this clear
    cmd_rdy_d   = cmd_rdy_q & ~clr_cmd_rdy;
    case (state_q)
      IDLE: begin
        if (rx_rdy) begin
          high_byte_d = rx_data;
          timer_d     = '0;
          cmd_rdy_d   = 1'b0;
        end
      end
      LOW_WAIT: begin
        if (rx_rdy) begin
          cmd_d     = {high_byte_q, rx_data};
          cmd_rdy_d = 1'b1;
        end else if (to_tc) begin
          frame_err   = 1'b1;
          high_byte_d = '0;
          timer_d     = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Framing datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_byte_q <= '0;
      timer_q     <= '0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
    end else begin
      high_byte_q <= high_byte_d;
      timer_q     <= timer_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
    end
  end

  // Response launch and completion tracking; requests while busy are dropped.
  always_comb begin
    trmt        = send_resp & ~tx_busy_q;
    tx_data     = resp;
    tx_busy_d   = tx_busy_q;
    resp_sent_d = resp_sent_q;
    if (tx_done) begin
      tx_busy_d   = 1'b0;
      resp_sent_d = 1'b1;
    end
    if (trmt) begin
      tx_busy_d   = 1'b1;
      resp_sent_d = 1'b0;
    end
  end

  // Response path registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy_q   <= 1'b0;
      resp_sent_q <= 1'b0;
    end else begin
      tx_busy_q   <= tx_busy_d;
      resp_sent_q <= resp_sent_d;
    end
  end

  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign resp_sent = resp_sent_q;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Self-checking bench for uart_cmd_wrapper: directed serial frames on RX,
// a byte-level reference model checked every cycle, and a TX decoder.
module tb_uart_cmd_wrapper;

  localparam int BIT     = 64;      // clocks per UART bit
  localparam int TO_CYC  = 60000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RX;
  logic        TX;
  logic        clr_cmd_rdy;
  logic        cmd_rdy;
  logic [15:0] cmd;
  logic        send_resp;
  logic [7:0]  resp;
  logic        resp_sent;
  logic        frame_err;

  uart_cmd_wrapper #(.TIMEOUT_CYC(TO_CYC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .clr_cmd_rdy (clr_cmd_rdy),
    .cmd_rdy     (cmd_rdy),
    .cmd         (cmd),
    .send_resp   (send_resp),
    .resp        (resp),
    .resp_sent   (resp_sent),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [7:0]  sent_q[$];     // bytes put on RX, consumed on arrival
  logic [7:0]  exp_tx_q[$];   // responses accepted, awaiting TX decode
  logic [15:0] exp_cmd   = '0;
  logic        exp_rdy   = 1'b0;
  logic        have_hi   = 1'b0;
  logic [7:0]  hi        = '0;
  int          hi_cyc    = 0;
  int          ferr_cnt  = 0;
  int          ferr_cyc  = 0;
  logic        exp_sent  = 1'b0;
  logic        tx_busy_m = 1'b0;
  int          tx_start  = 0;
  int          sent_dc   = -1;  // resp_sent unchecked up to this cycle
  int          tx_frames = 0;
  logic [7:0]  last_tx   = '0;

  // Per-cycle compare, then advance the model with this cycle's events.
  always @(negedge clk) begin
    logic       ferr_now;
    logic [7:0] b;
    if (!rst_n) begin
      chk("rst_cmd", cmd, 0);
      chk("rst_cmd_rdy", cmd_rdy, 0);
      chk("rst_resp_sent", resp_sent, 0);
      chk("rst_frame_err", frame_err, 0);
      sent_q.delete();
      exp_tx_q.delete();
      exp_cmd = '0; exp_rdy = 1'b0; have_hi = 1'b0;
      exp_sent = 1'b0; tx_busy_m = 1'b0; sent_dc = -1;
    end else begin
      ferr_now = have_hi && !dut.rx_rdy && (cyc - hi_cyc == TO_CYC);
      chk("cmd", cmd, exp_cmd);
      chk("cmd_rdy", cmd_rdy, exp_rdy);
      chk("frame_err", frame_err, ferr_now);
      if (cyc > sent_dc) chk("resp_sent", resp_sent, exp_sent);
      if (frame_err) begin ferr_cnt++; ferr_cyc = cyc; end

      if (dut.rx_rdy) begin
        if (sent_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rx_unexpected_byte: got a byte, expected none (cycle %0d)", cyc);
          b = '0;
        end else begin
          b = sent_q.pop_front();
        end
        if (!have_hi) begin
          have_hi = 1'b1; hi = b; hi_cyc = cyc; exp_rdy = 1'b0;
        end else begin
          exp_cmd = {hi, b}; exp_rdy = 1'b1; have_hi = 1'b0;
        end
      end else begin
        if (ferr_now) have_hi = 1'b0;
        if (clr_cmd_rdy) exp_rdy = 1'b0;
      end

      if (tx_busy_m && cyc == tx_start + 10*BIT) begin
        tx_busy_m = 1'b0; exp_sent = 1'b1; sent_dc = cyc + 4;
      end
      if (send_resp && !tx_busy_m) begin
        tx_busy_m = 1'b1; tx_start = cyc; exp_sent = 1'b0;
        exp_tx_q.push_back(resp);
      end
    end
    cyc++;
  end

  // TX line decoder: 8N1, sampled at bit centres.
  initial begin
    logic [7:0] rb;
    logic       stop_b;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && TX === 1'b0) begin
        repeat (BIT/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          rb[i] = TX;
        end
        repeat (BIT) @(negedge clk);
        stop_b = TX;
        tx_frames++;
        last_tx = rb;
        chk("tx_stop_bit", stop_b, 1);
        if (exp_tx_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL tx_extra_frame: got byte 0x%0h, expected no frame", rb);
        end else begin
          chk("tx_byte", rb, exp_tx_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic hold_bit(input logic v);
    RX = v;
    repeat (BIT) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    sent_q.push_back(b);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
    hold_bit(1'b1);
  endtask

  // Safety net: never hang.
  initial begin
    #(150000 * 10);
    $display("FAIL watchdog: got no finish, expected finish within 150000 cycles");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int n;
    RX = 1'b1; clr_cmd_rdy = 1'b0; send_resp = 1'b0; resp = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (4) tick();
    chk("reset_cmd", cmd, 16'h0000);
    chk("reset_cmd_rdy", cmd_rdy, 0);
    chk("reset_resp_sent", resp_sent, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_tx_idle", TX, 1);
    rst_n = 1'b1;
    repeat (4) tick();

    // back-to-back frame
    send_byte(8'hA5); send_byte(8'h3C); tick();
    chk("s1_cmd", cmd, 16'hA53C);
    chk("s1_cmd_rdy", cmd_rdy, 1);
    chk("s1_no_ferr", ferr_cnt, 0);

    // consumer clear, then a new frame
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    chk("s2_clr_rdy", cmd_rdy, 0);
    chk("s2_cmd_hold", cmd, 16'hA53C);
    send_byte(8'h11);
    chk("s2_hi_rdy", cmd_rdy, 0);
    chk("s2_hi_cmd", cmd, 16'hA53C);
    send_byte(8'h22); tick();
    chk("s2_cmd", cmd, 16'h1122);
    chk("s2_cmd_rdy", cmd_rdy, 1);

    // inter-byte timeout
    send_byte(8'h12);
    chk("s3_hi_clears_rdy", cmd_rdy, 0);
    n = 0;
    while (ferr_cnt == 0 && n < TO_CYC + 1000) begin tick(); n++; end
    chk("s3_ferr_seen", ferr_cnt, 1);
    chk("s3_ferr_delay", ferr_cyc - hi_cyc, TO_CYC);
    repeat (10) tick();
    chk("s3_ferr_single", ferr_cnt, 1);
    chk("s3_cmd_hold", cmd, 16'h1122);
    chk("s3_rdy_hold", cmd_rdy, 0);
    send_byte(8'h56); send_byte(8'h78); tick();
    chk("s3_cmd_resync", cmd, 16'h5678);
    chk("s3_cmd_rdy", cmd_rdy, 1);

    // clear on the exact completion cycle: set wins
    send_byte(8'hBE);
    fork
      send_byte(8'hEF);
      begin
        n = 0;
        while (dut.rx_rdy !== 1'b1 && n < 12*BIT) begin tick(); n++; end
        chk("s4_low_arrived", dut.rx_rdy, 1);
        clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
      end
    join
    tick();
    chk("s4_cmd", cmd, 16'hBEEF);
    chk("s4_cmd_rdy", cmd_rdy, 1);

    // response transmit, with a request while busy
    resp = 8'hA5; send_resp = 1'b1; tick(); send_resp = 1'b0;
    tick();
    chk("s5_sent_low", resp_sent, 0);
    repeat (300) tick();
    resp = 8'h5A; send_resp = 1'b1; tick(); send_resp = 1'b0;
    chk("s5_busy_sent_low", resp_sent, 0);
    n = 0;
    while (resp_sent !== 1'b1 && n < 1000) begin tick(); n++; end
    chk("s5_sent_high", resp_sent, 1);
    repeat (15*BIT) tick();
    chk("s5_tx_frames", tx_frames, 1);
    chk("s5_tx_byte", last_tx, 8'hA5);
    chk("s5_sent_sticky", resp_sent, 1);

    // reset mid-frame discards the pending high byte
    send_byte(8'h9C);
    rst_n = 1'b0; tick();
    chk("s6_rst_cmd", cmd, 16'h0000);
    chk("s6_rst_rdy", cmd_rdy, 0);
    chk("s6_rst_sent", resp_sent, 0);
    chk("s6_rst_ferr", frame_err, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    send_byte(8'hCA); send_byte(8'hFE); tick();
    chk("s6_cmd", cmd, 16'hCAFE);
    chk("s6_cmd_rdy", cmd_rdy, 1);
    chk("s6_no_ferr", ferr_cnt, 1);
    repeat (4) tick();
    chk("rx_bytes_consumed", sent_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
